// File: rtl/imp_var_isd_unit.sv
// imp_var_isd_unit: variance / integer-sqrt / reciprocal stage of the AILayerNorm datapath.
// Captures E[x] and E[x^2] on their done strobes, then computes
//   var = max(E[x^2] - E[x]^2, 0), std = floor(sqrt(var)), inv_std = min(2^16 / max(std,1), 65535)
// with bit-serial shift-subtract hardware. Fixed latency of 28 edges from the later strobe.
// Ports:
//   i_clk, i_rstn            clock, async active-low reset
//   i_Ex_done / i_Ex         E[x] strobe and signed 8-bit value
//   i_Ex2_done / i_Ex2       E[x^2] strobe and signed 16-bit value
//   o_busy                   high while the unit is not idle
//   o_done                   one-cycle pulse when o_var/o_std/o_inv_std update
//   o_var, o_std, o_inv_std  results, held until the next o_done or reset
module imp_var_isd_unit (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_Ex_done,
  input  logic signed [7:0]  i_Ex,
  input  logic               i_Ex2_done,
  input  logic signed [15:0] i_Ex2,
  output logic               o_busy,
  output logic               o_done,
  output logic [15:0]        o_var,
  output logic [7:0]         o_std,
  output logic [15:0]        o_inv_std
);

  localparam int unsigned EX_W       = 8;
  localparam int unsigned EX2_W      = 16;
  localparam int unsigned ROOT_W     = 8;
  localparam int unsigned SREM_W     = 10;
  localparam int unsigned QUO_W      = 17;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned SQRT_STEPS = 8;
  localparam int unsigned DIV_STEPS  = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VAR,
    S_SQRT,
    S_DIV,
    S_DONE
  } state_t;

  state_t                    state;
  logic signed [EX_W-1:0]    ex_r;
  logic signed [EX2_W-1:0]   ex2_r;
  logic                      ex_flag;
  logic                      ex2_flag;
  logic [EX2_W-1:0]          var_r;
  logic [EX2_W-1:0]          rad_r;
  logic [SREM_W-1:0]         srem_r;
  logic [ROOT_W-1:0]         root_r;
  logic [QUO_W-1:0]          dvd_r;
  logic [ROOT_W-1:0]         drem_r;
  logic [QUO_W-1:0]          quo_r;
  logic [CNT_W-1:0]          cnt_r;

  logic signed [EX2_W-1:0]   sq_c;
  logic signed [EX2_W:0]     diff_c;
  logic [EX2_W-1:0]          var_nx_c;
  logic [SREM_W+1:0]         srem_sh_c;
  logic [SREM_W+1:0]         strial_c;
  logic                      sfit_c;
  logic [SREM_W-1:0]         srem_nx_c;
  logic [ROOT_W-1:0]         divisor_c;
  logic [ROOT_W:0]           drem_sh_c;
  logic                      dfit_c;
  logic [ROOT_W-1:0]         drem_nx_c;

  // Variance with clamp, plus one step each of the sqrt and division iterations.
  always_comb begin
    sq_c      = 16'(ex_r) * 16'(ex_r);
    diff_c    = 17'(ex2_r) - 17'(sq_c);
    var_nx_c  = diff_c[EX2_W] ? '0 : diff_c[EX2_W-1:0];

    // Sqrt: bring down two radicand bits, try subtracting (4*root + 1).
    srem_sh_c = {srem_r, rad_r[EX2_W-1 -: 2]};
    strial_c  = {2'b00, root_r, 2'b01};
    sfit_c    = (srem_sh_c >= strial_c);
    srem_nx_c = sfit_c ? SREM_W'(srem_sh_c - strial_c) : SREM_W'(srem_sh_c);

    // Division: a zero root divides by one so std=0 saturates like std=1.
    divisor_c = (root_r == '0) ? ROOT_W'(1) : root_r;
    drem_sh_c = {drem_r, dvd_r[QUO_W-1]};
    dfit_c    = (drem_sh_c >= {1'b0, divisor_c});
    drem_nx_c = dfit_c ? ROOT_W'(drem_sh_c - {1'b0, divisor_c}) : ROOT_W'(drem_sh_c);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      ex_r      <= '0;
      ex2_r     <= '0;
      ex_flag   <= 1'b0;
      ex2_flag  <= 1'b0;
      var_r     <= '0;
      rad_r     <= '0;
      srem_r    <= '0;
      root_r    <= '0;
      dvd_r     <= '0;
      drem_r    <= '0;
      quo_r     <= '0;
      cnt_r     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_var     <= '0;
      o_std     <= '0;
      o_inv_std <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Ex_done) begin
            ex_r    <= i_Ex;
            ex_flag <= 1'b1;
          end
          if (i_Ex2_done) begin
            ex2_r    <= i_Ex2;
            ex2_flag <= 1'b1;
          end
          if (ex_flag && ex2_flag) begin
            state  <= S_VAR;
            o_busy <= 1'b1;
          end
        end

        S_VAR: begin
          var_r    <= var_nx_c;
          rad_r    <= var_nx_c;
          srem_r   <= '0;
          root_r   <= '0;
          cnt_r    <= '0;
          ex_flag  <= 1'b0;
          ex2_flag <= 1'b0;
          state    <= S_SQRT;
        end

        S_SQRT: begin
          srem_r <= srem_nx_c;
          root_r <= {root_r[ROOT_W-2:0], sfit_c};
          rad_r  <= {rad_r[EX2_W-3:0], 2'b00};
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(SQRT_STEPS - 1)) begin
            cnt_r  <= '0;
            dvd_r  <= QUO_W'(1) << 16;
            drem_r <= '0;
            quo_r  <= '0;
            state  <= S_DIV;
          end
        end

        S_DIV: begin
          drem_r <= drem_nx_c;
          dvd_r  <= {dvd_r[QUO_W-2:0], 1'b0};
          quo_r  <= {quo_r[QUO_W-2:0], dfit_c};
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(DIV_STEPS - 1)) begin
            cnt_r <= '0;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          o_var     <= var_r;
          o_std     <= root_r;
          o_inv_std <= quo_r[QUO_W-1] ? 16'hFFFF : quo_r[QUO_W-2:0];
          o_done    <= 1'b1;
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
